// File: rtl/uart8_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart8_tx_fifo
//  Brief    : Byte FIFO plus transmit sequencer feeding a Uart8 transmitter
//             through its level txStart/txBusy/txDone handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module uart8_tx_fifo #(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     start_err,
    output logic                     idle,
    output logic                     uart_txEn,
    output logic                     uart_txStart,
    output logic [7:0]               uart_txIn,
    input  logic                     uart_txBusy,
    input  logic                     uart_txDone
);

    localparam int c_addrW  = $clog2(DEPTH);
    localparam int c_levelW = c_addrW + 1;
    localparam int c_cntW   = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [c_levelW-1:0] c_levelFull = c_levelW'(DEPTH);
    localparam logic [c_cntW-1:0]   c_cntLast   = c_cntW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;

    logic [7:0]            r_mem [DEPTH];
    logic [c_addrW-1:0]    r_wrPtr;
    logic [c_addrW-1:0]    r_rdPtr;
    logic [c_levelW-1:0]   r_level;
    logic [c_levelW-1:0]   w_levelNext;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  r_startErr;
    logic                  r_idle;
    logic                  r_txStart;
    logic [7:0]            r_txIn;
    logic [c_cntW-1:0]     r_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_cntClear;
    logic                  w_txStartNext;
    logic                  w_startErrNext;
    logic                  w_emptyNext;

    // txDone is observed by the system but carries no control meaning here.
    logic                  w_unusedTxDone;
    assign w_unusedTxDone = uart_txDone;

    // Push decision uses the registered full flag, so a pop in the same
    // cycle never rescues a push into a full FIFO.
    assign w_push = wr_en && !r_full;

    // Occupancy bookkeeping for the next cycle.
    always_comb begin
        w_levelNext = r_level;
        case ({w_push, w_pop})
            2'b10:   w_levelNext = r_level + 1'b1;
            2'b01:   w_levelNext = r_level - 1'b1;
            default: w_levelNext = r_level;
        endcase
        w_emptyNext = (w_levelNext == '0);
    end

    // Sequencer next-state and registered-output decode.
    always_comb begin
        w_stateNext    = r_state;
        w_txStartNext  = 1'b0;
        w_startErrNext = 1'b0;
        w_pop          = 1'b0;
        w_load         = 1'b0;
        w_cntClear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && !r_empty) begin
                    w_stateNext   = START;
                    w_txStartNext = 1'b1;
                    w_load        = 1'b1;
                    w_cntClear    = 1'b1;
                end
            end
            START: begin
                w_txStartNext = 1'b1;
                if (uart_txBusy) begin
                    // The UART has taken the byte: only now is it popped.
                    w_pop         = 1'b1;
                    w_txStartNext = 1'b0;
                    w_stateNext   = BUSY;
                end else if (!enable) begin
                    w_txStartNext = 1'b0;
                    w_stateNext   = IDLE;
                end else if (r_cnt == c_cntLast) begin
                    w_txStartNext  = 1'b0;
                    w_startErrNext = 1'b1;
                    w_stateNext    = IDLE;
                end
            end
            BUSY: begin
                if (!uart_txBusy) begin
                    w_stateNext = GAP;
                end
            end
            GAP: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Sequencer state, handshake outputs and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_txStart  <= 1'b0;
            r_txIn     <= 8'h00;
            r_startErr <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_txStart  <= w_txStartNext;
            r_startErr <= w_startErrNext;
            if (w_load) begin
                r_txIn <= r_mem[r_rdPtr];
            end
            if (w_cntClear) begin
                r_cnt <= '0;
            end else if (r_state == START) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // FIFO pointers, level and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_idle     <= 1'b1;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_level    <= w_levelNext;
            r_full     <= (w_levelNext == c_levelFull);
            r_empty    <= w_emptyNext;
            r_overflow <= wr_en && r_full;
            r_idle     <= w_emptyNext && (w_stateNext == IDLE);
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    assign full         = r_full;
    assign empty        = r_empty;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign start_err    = r_startErr;
    assign idle         = r_idle;
    assign uart_txEn    = enable;
    assign uart_txStart = r_txStart;
    assign uart_txIn    = r_txIn;

endmodule
`default_nettype wire

// File: tb/tb_uart8_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart8_tx_fifo
//  Brief    : Self-checking bench for uart8_tx_fifo with a behavioural
//             Uart8 transmit responder and a byte scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart8_tx_fifo;

    localparam int DEPTH    = 16;
    localparam int TIMEOUT  = 8;
    localparam int BUSY_LEN = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       uart_txBusy = 1'b0;
    logic       uart_txDone = 1'b0;
    logic       full, empty, overflow, start_err, idle;
    logic       uart_txEn, uart_txStart;
    logic [7:0] uart_txIn;
    logic [4:0] level;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         rxCount = 0;
    int         expRx = 0;
    logic [7:0] sbQ[$];
    bit         respOn = 1'b0;
    bit         gapOn = 1'b0;
    bit         monOn = 1'b1;
    logic [7:0] heldTxIn = 8'h00;
    int         lowRun = 0;
    bit         seenBusy = 1'b0;

    uart8_tx_fifo #(.DEPTH(DEPTH), .START_TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .start_err    (start_err),
        .idle         (idle),
        .uart_txEn    (uart_txEn),
        .uart_txStart (uart_txStart),
        .uart_txIn    (uart_txIn),
        .uart_txBusy  (uart_txBusy),
        .uart_txDone  (uart_txDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit expectSent);
        wr_en   = 1'b1;
        wr_data = d;
        if (expectSent) begin
            sbQ.push_back(d);
            expRx++;
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        while (!(idle && !uart_txBusy) && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
        repeat (3) step();
    endtask

    // Behavioural Uart8 transmitter: accepts txStart, raises txBusy one
    // cycle later, captures txIn and checks it against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (respOn && rst_n && uart_txStart && !uart_txBusy) begin
                @(posedge clk);
                #1;
                if (uart_txStart) begin
                    uart_txBusy = 1'b1;
                    rxCount++;
                    if (sbQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rxByte: got 0x%0h, expected no byte", uart_txIn);
                    end else begin
                        chk("rxByte", 32'(uart_txIn), 32'(sbQ.pop_front()));
                    end
                    repeat (BUSY_LEN) @(posedge clk);
                    #1;
                    uart_txBusy = 1'b0;
                    uart_txDone = 1'b1;
                    @(posedge clk);
                    #1;
                    uart_txDone = 1'b0;
                end
            end
        end
    end

    // Line monitor: txStart low time between frames and txIn stability.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (uart_txBusy) seenBusy = 1'b1;
            if (uart_txStart) begin
                if (lowRun > 0) begin
                    if (gapOn && seenBusy) chk("txStartGapAtLeast2", 32'(lowRun >= 2), 32'd1);
                    seenBusy = 1'b0;
                    heldTxIn = uart_txIn;
                end else if (monOn) begin
                    chk("txInStableStart", 32'(uart_txIn), 32'(heldTxIn));
                end
                lowRun = 0;
            end else begin
                if (monOn && uart_txBusy) chk("txInStableBusy", 32'(uart_txIn), 32'(heldTxIn));
                lowRun++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic [4:0] expLevel;
        logic       expFull;
        logic       expOvf;
        bit         accept;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int n;
        int prevLevel;
        int t1;
        int t2;

        for (int i = 0; i < 17; i++) begin
            vecs[i].data     = 8'(8'h30 + i * 7);
            vecs[i].expLevel = (i < DEPTH) ? 5'(i + 1) : 5'(DEPTH);
            vecs[i].expFull  = (i >= DEPTH - 1);
            vecs[i].expOvf   = (i == DEPTH);
            vecs[i].accept   = (i < DEPTH);
        end

        // Reset state
        rst_n = 1'b0;
        repeat (10) step();
        chk("rstEmpty", 32'(empty), 32'd1);
        chk("rstLevel", 32'(level), 32'd0);
        chk("rstTxStart", 32'(uart_txStart), 32'd0);
        chk("rstIdle", 32'(idle), 32'd1);
        rst_n = 1'b1;
        step();
        chk("relEmpty", 32'(empty), 32'd1);
        chk("relFull", 32'(full), 32'd0);
        chk("relOverflow", 32'(overflow), 32'd0);
        chk("relStartErr", 32'(start_err), 32'd0);
        chk("relTxIn", 32'(uart_txIn), 32'd0);
        chk("txEnLow", 32'(uart_txEn), 32'd0);

        // Single byte, txStart latency of two cycles
        enable = 1'b1;
        respOn = 1'b1;
        gapOn  = 1'b1;
        #1;
        chk("txEnHigh", 32'(uart_txEn), 32'd1);
        step();
        push(8'h8A, 1'b1);
        chk("lat1Level", 32'(level), 32'd1);
        chk("lat1TxStart", 32'(uart_txStart), 32'd0);
        step();
        chk("lat2TxStart", 32'(uart_txStart), 32'd1);
        chk("lat2TxIn", 32'(uart_txIn), 32'h8A);
        chk("lat2Idle", 32'(idle), 32'd0);
        waitIdle(100, "singleDone");
        chk("singleRx", 32'(rxCount), 32'(expRx));
        chk("singleLevel", 32'(level), 32'd0);

        // Four back-to-back bytes, level counts down
        enable = 1'b0;
        push(8'h8A, 1'b1);
        push(8'h7A, 1'b1);
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        chk("fourLevel", 32'(level), 32'd4);
        enable = 1'b1;
        prevLevel = 4;
        n = 0;
        while (!(idle && !uart_txBusy) && n < 400) begin
            step();
            n++;
            if (32'(level) != prevLevel) begin
                chk("levelCountDown", 32'(level), 32'(prevLevel - 1));
                prevLevel = 32'(level);
            end
        end
        chk("fourDone", 32'(n < 400), 32'd1);
        repeat (3) step();
        chk("fourRx", 32'(rxCount), 32'(expRx));
        chk("fourSbEmpty", 32'(sbQ.size()), 32'd0);

        // Fill past DEPTH with the sequencer disabled
        enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(vecs[i].data, vecs[i].accept);
            chk("fillLevel", 32'(level), 32'(vecs[i].expLevel));
            chk("fillFull", 32'(full), 32'(vecs[i].expFull));
            chk("fillOverflow", 32'(overflow), 32'(vecs[i].expOvf));
        end
        step();
        chk("overflowOnePulse", 32'(overflow), 32'd0);
        chk("fullHeld", 32'(level), 32'd16);
        enable = 1'b1;
        waitIdle(800, "fillDrained");
        chk("fillRx", 32'(rxCount), 32'(expRx));
        chk("fillSbEmpty", 32'(sbQ.size()), 32'd0);
        chk("fillEmpty", 32'(empty), 32'd1);

        // START timeout with txBusy held low
        respOn = 1'b0;
        enable = 1'b0;
        push(8'h5A, 1'b1);
        enable = 1'b1;
        n = 0;
        while (!start_err && n < 40) begin step(); n++; end
        chk("startErrFirst", 32'(start_err), 32'd1);
        t1 = cyc;
        chk("startErrTxStart", 32'(uart_txStart), 32'd0);
        step();
        chk("startErrWidth", 32'(start_err), 32'd0);
        n = 0;
        while (!start_err && n < 40) begin step(); n++; end
        chk("startErrSecond", 32'(start_err), 32'd1);
        t2 = cyc;
        chk("startErrPeriod8to10", 32'((t2 - t1) >= 8 && (t2 - t1) <= 10), 32'd1);
        chk("startErrLevel", 32'(level), 32'd1);
        respOn = 1'b1;
        waitIdle(100, "retryDone");
        chk("retryRx", 32'(rxCount), 32'(expRx));

        // Enable dropped while in START
        respOn = 1'b0;
        enable = 1'b1;
        push(8'hC3, 1'b1);
        n = 0;
        while (!uart_txStart && n < 10) begin step(); n++; end
        chk("abortStartSeen", 32'(uart_txStart), 32'd1);
        enable = 1'b0;
        #1;
        chk("abortTxEn", 32'(uart_txEn), 32'd0);
        step();
        chk("abortTxStart", 32'(uart_txStart), 32'd0);
        chk("abortLevel", 32'(level), 32'd1);
        step();
        chk("abortStaysLow", 32'(uart_txStart), 32'd0);
        respOn = 1'b1;
        enable = 1'b1;
        waitIdle(100, "abortRetryDone");
        chk("abortRx", 32'(rxCount), 32'(expRx));

        // Asynchronous reset while BUSY
        enable = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        enable = 1'b1;
        n = 0;
        while (!(uart_txBusy && !uart_txStart) && n < 20) begin step(); n++; end
        chk("rstBusyReached", 32'(uart_txBusy && !uart_txStart), 32'd1);
        chk("rstBusyLevel", 32'(level), 32'd1);
        monOn = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstAsyncTxStart", 32'(uart_txStart), 32'd0);
        chk("rstAsyncLevel", 32'(level), 32'd0);
        chk("rstAsyncEmpty", 32'(empty), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        while (uart_txBusy && n < 20) begin step(); n++; end
        repeat (5) step();
        chk("postRstIdle", 32'(idle), 32'd1);
        chk("postRstTxStart", 32'(uart_txStart), 32'd0);
        chk("postRstRx", 32'(rxCount), 32'(expRx));
        chk("postRstSbEmpty", 32'(sbQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
